// File: rtl/apb_biu_ws_if.sv
// APB4 bus bundle between the fabric (master) and a peripheral BIU (slave).
interface apb_biu_ws_if #(
  parameter int ADDR_LHS = 10,
  parameter int DATA_W   = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_LHS:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_biu_ws.sv
// APB4 bus-interface unit with IP-driven wait states, byte strobes,
// out-of-range / ack-timeout error responses and 32/64-bit data width.
// Each APB access becomes a one-cycle wr_en/rd_en pulse toward the
// register bank; the IP finishes the access by raising ip_ack.
module apb_biu_ws #(
  parameter int ADDR_LHS = 10,
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 64,
  parameter int TIMEOUT  = 16,
  localparam int AW_LSB  = $clog2(DATA_W / 8),
  localparam int RA_W    = ADDR_LHS - AW_LSB + 1,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_biu_ws_if.slave       apb,
  output logic              wr_en,
  output logic              rd_en,
  output logic [RA_W-1:0]   reg_addr,
  output logic [DATA_W-1:0] ipwdata,
  output logic [STRB_W-1:0] ipstrb,
  input  logic [DATA_W-1:0] iprdata,
  input  logic              ip_ack
);

  // A zero TIMEOUT still needs a 1-bit counter so the vector is legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [31:0] REG_NUM_U = 32'(REG_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] prdata_reg, prdata_next;
  logic              pready_reg, pready_next;
  logic              pslverr_reg, pslverr_next;
  logic              wr_en_reg, wr_en_next;
  logic              rd_en_reg, rd_en_next;
  logic [RA_W-1:0]   reg_addr_reg;
  logic [DATA_W-1:0] ipwdata_reg;
  logic [STRB_W-1:0] ipstrb_reg;
  logic              write_reg;
  logic              capture;

  logic [RA_W-1:0]   word_idx;
  logic              setup_phase;
  logic              out_of_range;

  assign word_idx     = apb.paddr[ADDR_LHS:AW_LSB];
  assign setup_phase  = apb.psel && !apb.penable;
  assign out_of_range = (32'(word_idx) >= REG_NUM_U);

  // Next-state and next-output decode for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    prdata_next  = prdata_reg;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    capture      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (setup_phase) begin
          capture = 1'b1;
          if (out_of_range) begin
            // Answer immediately with an error; the IP never sees it.
            state_next   = ST_RESP;
            pready_next  = 1'b1;
            pslverr_next = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = '0;
            wr_en_next = apb.pwrite;
            rd_en_next = !apb.pwrite;
          end
        end
      end

      ST_WAIT: begin
        if (!apb.psel) begin
          // Master abandoned the transfer: no response is produced.
          state_next = ST_IDLE;
        end else if (ip_ack) begin
          // Ack has priority over a timeout in the same cycle.
          state_next  = ST_RESP;
          pready_next = 1'b1;
          if (!write_reg) begin
            prdata_next = iprdata;
          end
        end else if (TO_EN && (cnt_reg == TO_LAST)) begin
          state_next   = ST_RESP;
          pready_next  = 1'b1;
          pslverr_next = 1'b1;
          if (!write_reg) begin
            prdata_next = '0;
          end
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered APB/IP outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      prdata_reg  <= prdata_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
    end
  end

  // Request attributes are held from the setup phase until the next one.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      reg_addr_reg <= '0;
      ipwdata_reg  <= '0;
      ipstrb_reg   <= '0;
      write_reg    <= 1'b0;
    end else if (capture) begin
      reg_addr_reg <= word_idx;
      ipwdata_reg  <= apb.pwdata;
      ipstrb_reg   <= apb.pstrb;
      write_reg    <= apb.pwrite;
    end
  end

  assign apb.prdata  = prdata_reg;
  assign apb.pready  = pready_reg;
  assign apb.pslverr = pslverr_reg;
  assign wr_en       = wr_en_reg;
  assign rd_en       = rd_en_reg;
  assign reg_addr    = reg_addr_reg;
  assign ipwdata     = ipwdata_reg;
  assign ipstrb      = ipstrb_reg;

endmodule

// File: tb/tb_apb_biu_ws.sv
// Directed bench for apb_biu_ws: a 32-bit instance (TIMEOUT=16) and a
// 64-bit instance (TIMEOUT=4), both with REG_NUM=64, sharing the stimulus
// bus; only one instance is selected at a time.
module tb_apb_biu_ws;

  localparam logic [63:0] ZERO = 64'd0;
  localparam logic [63:0] ONE  = 64'd1;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        a_psel, b_psel, penable, pwrite;
  logic [10:0] paddr;
  logic [63:0] pwdata, iprdata;
  logic [7:0]  pstrb;
  logic        ip_ack;
  logic        use_b;
  int          n_checks;
  int          n_errors;

  always #5 pclk = ~pclk;

  apb_biu_ws_if #(.ADDR_LHS(10), .DATA_W(32)) a_if ();
  apb_biu_ws_if #(.ADDR_LHS(10), .DATA_W(64)) b_if ();

  assign a_if.psel    = a_psel;
  assign a_if.penable = penable;
  assign a_if.pwrite  = pwrite;
  assign a_if.paddr   = paddr;
  assign a_if.pwdata  = pwdata[31:0];
  assign a_if.pstrb   = pstrb[3:0];
  assign b_if.psel    = b_psel;
  assign b_if.penable = penable;
  assign b_if.pwrite  = pwrite;
  assign b_if.paddr   = paddr;
  assign b_if.pwdata  = pwdata;
  assign b_if.pstrb   = pstrb;

  logic        a_wr_en, a_rd_en, b_wr_en, b_rd_en;
  logic [8:0]  a_reg_addr;
  logic [7:0]  b_reg_addr;
  logic [31:0] a_ipwdata;
  logic [63:0] b_ipwdata;
  logic [3:0]  a_ipstrb;
  logic [7:0]  b_ipstrb;

  apb_biu_ws #(.ADDR_LHS(10), .DATA_W(32), .REG_NUM(64), .TIMEOUT(16)) dut_a (
    .pclk     (pclk),
    .presetn  (presetn),
    .apb      (a_if.slave),
    .wr_en    (a_wr_en),
    .rd_en    (a_rd_en),
    .reg_addr (a_reg_addr),
    .ipwdata  (a_ipwdata),
    .ipstrb   (a_ipstrb),
    .iprdata  (iprdata[31:0]),
    .ip_ack   (ip_ack)
  );

  apb_biu_ws #(.ADDR_LHS(10), .DATA_W(64), .REG_NUM(64), .TIMEOUT(4)) dut_b (
    .pclk     (pclk),
    .presetn  (presetn),
    .apb      (b_if.slave),
    .wr_en    (b_wr_en),
    .rd_en    (b_rd_en),
    .reg_addr (b_reg_addr),
    .ipwdata  (b_ipwdata),
    .ipstrb   (b_ipstrb),
    .iprdata  (iprdata),
    .ip_ack   (ip_ack)
  );

  // Observed outputs of whichever instance is selected, widened to 64 bits.
  wire [63:0] o_prdata   = use_b ? b_if.prdata : {32'h0, a_if.prdata};
  wire [63:0] o_pready   = {63'h0, use_b ? b_if.pready : a_if.pready};
  wire [63:0] o_pslverr  = {63'h0, use_b ? b_if.pslverr : a_if.pslverr};
  wire [63:0] o_wr_en    = {63'h0, use_b ? b_wr_en : a_wr_en};
  wire [63:0] o_rd_en    = {63'h0, use_b ? b_rd_en : a_rd_en};
  wire [63:0] o_reg_addr = use_b ? {56'h0, b_reg_addr} : {55'h0, a_reg_addr};
  wire [63:0] o_ipwdata  = use_b ? b_ipwdata : {32'h0, a_ipwdata};
  wire [63:0] o_ipstrb   = use_b ? {56'h0, b_ipstrb} : {60'h0, a_ipstrb};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic setup(input bit sel_b, input bit wr, input logic [10:0] addr,
                       input logic [63:0] wd, input logic [7:0] st);
    use_b   = sel_b;
    a_psel  = !sel_b;
    b_psel  = sel_b;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = st;
  endtask

  task automatic access();
    penable = 1'b1;
  endtask

  task automatic idle();
    a_psel  = 1'b0;
    b_psel  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    ip_ack  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    presetn  = 1'b0;
    use_b    = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = '0;
    iprdata  = '0;
    idle();
    repeat (2) tick();

    // Reset values
    check("rst_prdata", o_prdata, ZERO);
    check("rst_pready", o_pready, ZERO);
    check("rst_pslverr", o_pslverr, ZERO);
    check("rst_wr_en", o_wr_en, ZERO);
    check("rst_rd_en", o_rd_en, ZERO);
    check("rst_reg_addr", o_reg_addr, ZERO);
    check("rst_ipwdata", o_ipwdata, ZERO);
    check("rst_ipstrb", o_ipstrb, ZERO);
    use_b = 1'b1;
    check("rst_b_prdata", o_prdata, ZERO);
    check("rst_b_pready", o_pready, ZERO);
    use_b = 1'b0;
    presetn = 1'b1;
    tick();
    $display("[tb] txn reset: done");

    // Read, ack in first WAIT cycle
    setup(1'b0, 1'b0, 11'h010, ZERO, 8'h0F);
    tick();
    check("rd_rd_en", o_rd_en, ONE);
    check("rd_wr_en", o_wr_en, ZERO);
    check("rd_reg_addr", o_reg_addr, 64'd4);
    access();
    ip_ack  = 1'b1;
    iprdata = 64'hA5A5_0001;
    tick();
    check("rd_pready", o_pready, ONE);
    check("rd_pslverr", o_pslverr, ZERO);
    check("rd_prdata", o_prdata, 64'hA5A5_0001);
    check("rd_rd_en_low", o_rd_en, ZERO);
    ip_ack = 1'b0;
    tick();
    check("rd_pready_low", o_pready, ZERO);
    idle();
    $display("[tb] txn read 0x010: done");

    // Write, ack three cycles late
    setup(1'b0, 1'b1, 11'h008, 64'h1234_5678, 8'h03);
    tick();
    check("wr_wr_en", o_wr_en, ONE);
    check("wr_rd_en", o_rd_en, ZERO);
    check("wr_reg_addr", o_reg_addr, 64'd2);
    check("wr_ipwdata", o_ipwdata, 64'h1234_5678);
    check("wr_ipstrb", o_ipstrb, 64'h3);
    access();
    tick();
    check("wr_wr_en_once", o_wr_en, ZERO);
    check("wr_pready_c2", o_pready, ZERO);
    tick();
    tick();
    check("wr_pready_c4", o_pready, ZERO);
    ip_ack  = 1'b1;
    iprdata = 64'hDEAD_BEEF;
    tick();
    check("wr_pready", o_pready, ONE);
    check("wr_pslverr", o_pslverr, ZERO);
    check("wr_prdata_kept", o_prdata, 64'hA5A5_0001);
    ip_ack = 1'b0;
    tick();
    check("wr_pready_low", o_pready, ZERO);
    idle();
    $display("[tb] txn write 0x008 delayed ack: done");

    // Write with zero strobes to the last valid word
    setup(1'b0, 1'b1, 11'h0FC, 64'h55, 8'h00);
    tick();
    check("wz_wr_en", o_wr_en, ONE);
    check("wz_reg_addr", o_reg_addr, 64'd63);
    check("wz_ipstrb", o_ipstrb, ZERO);
    access();
    ip_ack = 1'b1;
    tick();
    check("wz_pready", o_pready, ONE);
    ip_ack = 1'b0;
    tick();
    idle();
    $display("[tb] txn write 0x0FC zero strobe: done");

    // Out-of-range read
    setup(1'b0, 1'b0, 11'h100, ZERO, 8'h00);
    tick();
    check("oor_pready", o_pready, ONE);
    check("oor_pslverr", o_pslverr, ONE);
    check("oor_rd_en", o_rd_en, ZERO);
    access();
    tick();
    check("oor_pready_low", o_pready, ZERO);
    check("oor_rd_en_c2", o_rd_en, ZERO);
    idle();
    $display("[tb] txn read 0x100 out of range: done");

    // Timeout read, late ack ignored
    setup(1'b0, 1'b0, 11'h004, ZERO, 8'h00);
    tick();
    check("to_rd_en", o_rd_en, ONE);
    access();
    repeat (15) tick();
    check("to_pready_c16", o_pready, ZERO);
    tick();
    check("to_pready", o_pready, ONE);
    check("to_pslverr", o_pslverr, ONE);
    check("to_prdata", o_prdata, ZERO);
    tick();
    check("to_pready_low", o_pready, ZERO);
    idle();
    tick();
    tick();
    ip_ack  = 1'b1;
    iprdata = 64'hFFFF_FFFF;
    tick();
    check("late_ack_pready", o_pready, ZERO);
    check("late_ack_rd_en", o_rd_en, ZERO);
    check("late_ack_prdata", o_prdata, ZERO);
    ip_ack = 1'b0;
    $display("[tb] txn read 0x004 timeout: done");

    // Reset asserted in second WAIT cycle
    setup(1'b0, 1'b0, 11'h00C, ZERO, 8'h00);
    tick();
    access();
    tick();
    presetn = 1'b0;
    #1;
    check("arst_reg_addr", o_reg_addr, ZERO);
    check("arst_rd_en", o_rd_en, ZERO);
    check("arst_pready", o_pready, ZERO);
    check("arst_pslverr", o_pslverr, ZERO);
    idle();
    tick();
    presetn = 1'b1;
    tick();
    setup(1'b0, 1'b0, 11'h00C, ZERO, 8'h00);
    tick();
    check("post_rst_rd_en", o_rd_en, ONE);
    check("post_rst_reg_addr", o_reg_addr, 64'd3);
    access();
    ip_ack  = 1'b1;
    iprdata = 64'h0BAD_F00D;
    tick();
    check("post_rst_pready", o_pready, ONE);
    check("post_rst_pslverr", o_pslverr, ZERO);
    check("post_rst_prdata", o_prdata, 64'h0BAD_F00D);
    ip_ack = 1'b0;
    tick();
    idle();
    $display("[tb] txn reset mid-wait and recovery read: done");

    // psel dropped in WAIT
    setup(1'b0, 1'b0, 11'h014, ZERO, 8'h00);
    tick();
    check("abort_rd_en", o_rd_en, ONE);
    a_psel  = 1'b0;
    penable = 1'b0;
    tick();
    check("abort_pready_c2", o_pready, ZERO);
    ip_ack  = 1'b1;
    iprdata = 64'h1111;
    tick();
    check("abort_pready_c3", o_pready, ZERO);
    check("abort_prdata", o_prdata, 64'h0BAD_F00D);
    idle();
    $display("[tb] txn abort in wait: done");

    // 64-bit: ack and timeout coincide at cycle 4
    setup(1'b1, 1'b0, 11'h1F8, ZERO, 8'h00);
    tick();
    check("b_co_rd_en", o_rd_en, ONE);
    check("b_co_reg_addr", o_reg_addr, 64'h3F);
    access();
    tick();
    tick();
    tick();
    check("b_co_pready_c4", o_pready, ZERO);
    ip_ack  = 1'b1;
    iprdata = 64'h0123_4567_89AB_CDEF;
    tick();
    check("b_co_pready", o_pready, ONE);
    check("b_co_pslverr", o_pslverr, ZERO);
    check("b_co_prdata", o_prdata, 64'h0123_4567_89AB_CDEF);
    ip_ack = 1'b0;
    tick();
    idle();
    $display("[tb] txn b read 0x1F8 ack at timeout: done");

    // 64-bit: first out-of-range word, reg_addr from paddr[10:3]
    setup(1'b1, 1'b0, 11'h200, ZERO, 8'h00);
    tick();
    check("b_oor_pready", o_pready, ONE);
    check("b_oor_pslverr", o_pslverr, ONE);
    check("b_oor_rd_en", o_rd_en, ZERO);
    check("b_oor_reg_addr", o_reg_addr, 64'h40);
    access();
    tick();
    idle();
    $display("[tb] txn b read 0x200 out of range: done");

    // 64-bit: back-to-back read then write, 3+3 cycles
    setup(1'b1, 1'b0, 11'h018, ZERO, 8'h00);
    tick();
    check("b2b_rd_en", o_rd_en, ONE);
    check("b2b_rd_reg_addr", o_reg_addr, 64'd3);
    access();
    ip_ack  = 1'b1;
    iprdata = 64'hFEED_FACE_0000_0018;
    tick();
    check("b2b_rd_pready", o_pready, ONE);
    check("b2b_rd_prdata", o_prdata, 64'hFEED_FACE_0000_0018);
    ip_ack = 1'b0;
    tick();
    check("b2b_gap_pready", o_pready, ZERO);
    setup(1'b1, 1'b1, 11'h020, 64'hCAFE_BABE_1357_9BDF, 8'hF0);
    tick();
    check("b2b_wr_en", o_wr_en, ONE);
    check("b2b_wr_reg_addr", o_reg_addr, 64'd4);
    check("b2b_ipwdata", o_ipwdata, 64'hCAFE_BABE_1357_9BDF);
    check("b2b_ipstrb", o_ipstrb, 64'hF0);
    access();
    ip_ack = 1'b1;
    tick();
    check("b2b_wr_pready", o_pready, ONE);
    check("b2b_wr_pslverr", o_pslverr, ZERO);
    check("b2b_wr_prdata_kept", o_prdata, 64'hFEED_FACE_0000_0018);
    ip_ack = 1'b0;
    tick();
    check("b2b_pready_low", o_pready, ZERO);
    idle();
    $display("[tb] txn b back-to-back read/write: done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
